// File: rtl/vga_scandoubler_if.sv
// Pixel/sync stream into and out of the scandoubler, plus the strobes that pace it.
interface vga_scandoubler_if #(
  parameter int ADDR_W = 9
);
  logic              ck7;
  logic              ck14;
  logic              en;
  logic [1:0]        r_i;
  logic [1:0]        g_i;
  logic [1:0]        b_i;
  logic              hsync_i;
  logic              vsync_i;
  logic [1:0]        r_o;
  logic [1:0]        g_o;
  logic [1:0]        b_o;
  logic              hsync_o;
  logic              vsync_o;
  logic [ADDR_W-1:0] line_len;

  modport master (
    output ck7, ck14, en, r_i, g_i, b_i, hsync_i, vsync_i,
    input  r_o, g_o, b_o, hsync_o, vsync_o, line_len
  );

  modport slave (
    input  ck7, ck14, en, r_i, g_i, b_i, hsync_i, vsync_i,
    output r_o, g_o, b_o, hsync_o, vsync_o, line_len
  );
endinterface

// File: rtl/vga_scandoubler.sv
// 15.6 kHz -> 31 kHz line doubler: ping-pong line buffer written at ck7,
// the other bank replayed twice per input line at ck14. en=0 bypasses.
module vga_scandoubler #(
  parameter int ADDR_W = 9,
  parameter int HS_LEN = 54
) (
  input logic              clk28,
  input logic              rst,
  vga_scandoubler_if.slave vif
);
  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] X_MAX  = '1;
  localparam logic [ADDR_W-1:0] HS_END = ADDR_W'(HS_LEN);

  logic [5:0]        mem [2*DEPTH];
  logic [ADDR_W-1:0] wr_x;
  logic [ADDR_W-1:0] rd_x;
  logic [ADDR_W-1:0] line_len;
  logic              wr_bank;
  logic              hs_prev;
  logic              fall;
  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rd_addr;
  logic [5:0]        rd_pix;
  logic              rd_hs_n;
  logic              rd_black;
  logic              short_line;
  logic [5:0]        pix_q;
  logic              hs_q;
  logic              vs_q;

  assign fall       = vif.ck7 & hs_prev & ~vif.hsync_i;
  // The fall pixel always lands in the new bank, even if the old line saturated.
  assign wr_en      = vif.ck7 & (fall | (wr_x != X_MAX));
  assign wr_addr    = fall ? {~wr_bank, {ADDR_W{1'b0}}} : {wr_bank, wr_x};
  assign rd_addr    = {~wr_bank, rd_x};
  assign rd_pix     = mem[rd_addr];
  assign short_line = line_len < ADDR_W'(2);
  assign rd_hs_n    = rd_x >= HS_END;
  assign rd_black   = ~rd_hs_n | (rd_x >= line_len) | short_line;

  always_ff @(posedge clk28) begin
    if (wr_en) mem[wr_addr] <= {vif.r_i, vif.g_i, vif.b_i};
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      wr_x     <= '0;
      rd_x     <= '0;
      line_len <= '0;
      wr_bank  <= 1'b0;
      hs_prev  <= 1'b1;
    end else begin
      if (vif.ck7) hs_prev <= vif.hsync_i;
      if (fall) begin
        line_len <= wr_x;
        wr_bank  <= ~wr_bank;
        wr_x     <= ADDR_W'(1);
        rd_x     <= '0;
      end else begin
        if (vif.ck7 && wr_x != X_MAX) wr_x <= wr_x + 1'b1;
        // Wrap at the end of the stored line; replay repeats until the next fall.
        if (vif.ck14) begin
          if (short_line || rd_x >= line_len - 1'b1) rd_x <= '0;
          else                                       rd_x <= rd_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (!vif.en) begin
      pix_q <= {vif.r_i, vif.g_i, vif.b_i};
      hs_q  <= vif.hsync_i;
      vs_q  <= vif.vsync_i;
    end else if (vif.ck14) begin
      pix_q <= rd_black ? 6'd0 : rd_pix;
      hs_q  <= rd_hs_n;
      vs_q  <= vif.vsync_i;
    end
  end

  assign vif.r_o      = pix_q[5:4];
  assign vif.g_o      = pix_q[3:2];
  assign vif.b_o      = pix_q[1:0];
  assign vif.hsync_o  = hs_q;
  assign vif.vsync_o  = vs_q;
  assign vif.line_len = line_len;
endmodule
